// File: rtl/approx_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : approx_div_pkg
//  Purpose  : Shared types and cell functions for the approximate sequential
//             divider: FSM state encoding plus the exact and approximate
//             one-bit subtractor equations.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package approx_div_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // The approximate cell drives a constant difference bit, so a low row
    // in approximate mode always restores to all ones when it subtracts.
    localparam logic C_APPROX_DIFF = 1'b1;

    function automatic logic exact_diff(input logic x, input logic y, input logic bin);
        return x ^ y ^ bin;
    endfunction

    function automatic logic exact_bout(input logic x, input logic y, input logic bin);
        return (~x & y) | (~(x ^ y) & bin);
    endfunction

    // Borrow-in is deliberately ignored: the chain no longer ripples, which
    // is where the switching-power saving comes from.
    function automatic logic approx_bout(input logic x, input logic y);
        return ~x | y;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_cell_sel.sv
`default_nettype none
// ============================================================================
//  Module   : div_cell_sel
//  Purpose  : One-bit subtractor cell with runtime exact/approximate select.
//  Ports    : x, y, bin   - minuend, subtrahend, borrow-in
//             approx      - 1 selects the approximate cell function
//             diff, bout  - difference and borrow-out
//  Revision : 1.0  initial release
// ============================================================================
module div_cell_sel
    import approx_div_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic bin,
    input  logic approx,
    output logic diff,
    output logic bout
);

    always_comb begin
        if (approx) begin
            diff = C_APPROX_DIFF;
            bout = approx_bout(x, y);
        end else begin
            diff = exact_diff(x, y, bin);
            bout = exact_bout(x, y, bin);
        end
    end

endmodule
`default_nettype wire

// File: rtl/approx_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : approx_seq_divider
//  Purpose  : Iterative radix-2 restoring divider, one quotient bit per clock
//             through a single row of selectable exact/approximate cells.
//  Ports    : clk, rst          - clock, async active-high reset
//             start, mode_exact - request and accuracy mode (captured on accept)
//             n [DW+QW], d [DW] - dividend and divisor (captured on accept)
//             ready, busy, done - handshake status (done is a 1-cycle pulse)
//             q [QW], r [DW]    - quotient and remainder
//             dz, ovf           - divide-by-zero and quotient-overflow flags
//  Revision : 1.0  initial release
// ============================================================================
module approx_seq_divider
    import approx_div_pkg::*;
#(
    parameter int DW          = 8,
    parameter int QW          = 8,
    parameter int APPROX_ROWS = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode_exact,
    input  logic [DW+QW-1:0] n,
    input  logic [DW-1:0]    d,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [QW-1:0]    q,
    output logic [DW-1:0]    r,
    output logic             dz,
    output logic             ovf
);

    localparam int NW = DW + QW;
    localparam int IW = (QW > 1) ? $clog2(QW) : 1;

    if (APPROX_ROWS > QW || APPROX_ROWS < 0 || DW < 1) begin : g_param_check
        $error("approx_seq_divider: illegal parameters DW=%0d QW=%0d APPROX_ROWS=%0d",
               DW, QW, APPROX_ROWS);
    end

    state_t          r_state;
    state_t          w_next;
    logic [NW-1:0]   r_n;
    logic [DW-1:0]   r_d;
    logic            r_mode_exact;
    logic [DW:0]     r_win;
    logic [IW-1:0]   r_idx;

    logic            w_accept;
    logic            w_last;
    logic            w_approx;
    logic            w_top;
    logic [DW-1:0]   w_x;
    logic [DW-1:0]   w_diff;
    logic [DW:0]     w_borrow;
    logic            w_qbit;
    logic [DW-1:0]   w_rem;

    assign w_accept = start && (r_state != S_RUN);
    assign w_last   = (r_state == S_RUN) && (r_idx == '0);

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (r_idx == '0) w_next = S_DONE;
            S_DONE:  w_next = start ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Single subtractor row, shared by every iteration
    // ------------------------------------------------------------------
    assign w_top      = r_win[DW];
    assign w_x        = r_win[DW-1:0];
    assign w_approx   = ~r_mode_exact && (int'(r_idx) < APPROX_ROWS);
    assign w_borrow[0] = 1'b0;

    for (genvar gi = 0; gi < DW; gi++) begin : g_row
        div_cell_sel u_cell (
            .x      (w_x[gi]),
            .y      (r_d[gi]),
            .bin    (w_borrow[gi]),
            .approx (w_approx),
            .diff   (w_diff[gi]),
            .bout   (w_borrow[gi+1])
        );
    end

    // A set window MSB means the partial remainder already exceeds d, so
    // the subtraction is taken regardless of the row's borrow-out.
    assign w_qbit = w_top | ~w_borrow[DW];
    assign w_rem  = w_qbit ? w_diff : w_x;

    // ------------------------------------------------------------------
    // State, datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_n          <= '0;
            r_d          <= '0;
            r_mode_exact <= 1'b1;
            r_win        <= '0;
            r_idx        <= '0;
            ready        <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            q            <= '0;
            r            <= '0;
            dz           <= 1'b0;
            ovf          <= 1'b0;
        end else begin
            r_state <= w_next;
            ready   <= (w_next != S_RUN);
            busy    <= (w_next == S_RUN);
            done    <= w_last;

            if (w_accept) begin
                r_n          <= n;
                r_d          <= d;
                r_mode_exact <= mode_exact;
                r_win        <= n[NW-1:QW-1];
                r_idx        <= IW'(QW - 1);
                q            <= '0;
                dz           <= (d == '0);
                ovf          <= (n[NW-1:QW] >= d);
            end else if (r_state == S_RUN) begin
                q[r_idx] <= w_qbit;
                if (r_idx != '0) begin
                    r_win <= {w_rem, r_n[r_idx - IW'(1)]};
                    r_idx <= r_idx - IW'(1);
                end else begin
                    r <= w_rem;
                end
            end
        end
    end

endmodule
`default_nettype wire
